// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-port memory bus arbiter.
package mem_bus_pkg;

   localparam int MEM_ADDR_W = 32;
   localparam int MEM_DATA_W = 128;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } arb_state_t;

   typedef struct packed {
      logic                  we;
      logic [MEM_ADDR_W-1:0] addr;
      logic [MEM_DATA_W-1:0] wdata;
   } mem_cmd_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way request picker. MEM_BUS_ARB_RR_EN selects round-robin; otherwise
// port 1 (data side) has fixed priority and last_grant is ignored.
module mem_arb_pick
   import mem_bus_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant_valid,
   output logic       grant_id
);

   assign grant_valid = |req;

`ifdef MEM_BUS_ARB_RR_EN
   always_comb begin
      grant_id = PORT_D;
      if (req == 2'b11)
         grant_id = ~last_grant;
      else if (req[0])
         grant_id = PORT_I;
   end
`else
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
   assign grant_id = req[1] ? PORT_D : PORT_I;
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbiter/sequencer for the shared 128-bit SoC memory bus (icache port 0, dcache port 1).
// Define MEM_BUS_ARB_RR_EN for round-robin arbitration instead of fixed port-1 priority.
//
// state  | meaning
// IDLE   | bus quiet, pick a requester and latch its command
// ACCESS | bus driven with latched command for MEM_LAT cycles
// RESP   | bus quiet, one-cycle ack with rdata to the winner
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W  = MEM_ADDR_W,
   parameter int DATA_W  = MEM_DATA_W,
   parameter int MEM_LAT = 2,
   parameter int CNT_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_ack,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_ack,
   output logic [DATA_W-1:0] p1_rdata,
   output logic [ADDR_W-1:0] mem_addr_sel,
   output logic [DATA_W-1:0] mem_dat_o,
   input  logic [DATA_W-1:0] mem_dat_i,
   output logic              mem_dat_oe,
   output logic              mem_en,
   output logic              mem_we,
   output logic              mem_re
);

   arb_state_t        state;
   mem_cmd_t          cmd;
   mem_cmd_t          sel_cmd;
   logic              winner;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] rdata;
   logic              last_grant;
   logic              grant_valid;
   logic              grant_id;

   mem_arb_pick u_pick (
      .req         ({p1_req, p0_req}),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

`ifdef MEM_BUS_ARB_RR_EN
   always_ff @(posedge clk) begin
      if (rst)
         last_grant <= PORT_D;
      else if (state == IDLE && grant_valid)
         last_grant <= grant_id;
   end
`else
   assign last_grant = PORT_D;
`endif

   // Read commands carry zero wdata so mem_dat_o stays quiet when not writing.
   always_comb begin
      sel_cmd = '0;
      if (grant_id == PORT_D) begin
         sel_cmd.we    = p1_we;
         sel_cmd.addr  = p1_addr;
         sel_cmd.wdata = p1_we ? p1_wdata : '0;
      end else begin
         sel_cmd.we    = p0_we;
         sel_cmd.addr  = p0_addr;
         sel_cmd.wdata = p0_we ? p0_wdata : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         winner     <= PORT_I;
         cmd        <= '0;
         rdata      <= '0;
         p0_ack     <= 1'b0;
         p1_ack     <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_re     <= 1'b0;
         mem_dat_oe <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  winner     <= grant_id;
                  cmd        <= sel_cmd;
                  cnt        <= CNT_W'(MEM_LAT - 1);
                  mem_en     <= 1'b1;
                  mem_we     <= sel_cmd.we;
                  mem_re     <= ~sel_cmd.we;
                  mem_dat_oe <= sel_cmd.we;
                  state      <= ACCESS;
               end
            end
            ACCESS: begin
               if (cnt == '0) begin
                  rdata      <= cmd.we ? '0 : mem_dat_i;
                  cmd        <= '0;
                  mem_en     <= 1'b0;
                  mem_we     <= 1'b0;
                  mem_re     <= 1'b0;
                  mem_dat_oe <= 1'b0;
                  p0_ack     <= (winner == PORT_I);
                  p1_ack     <= (winner == PORT_D);
                  state      <= RESP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            RESP: begin
               p0_ack <= 1'b0;
               p1_ack <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign mem_addr_sel = cmd.addr;
   assign mem_dat_o    = cmd.wdata;
   assign p0_rdata     = rdata;
   assign p1_rdata     = rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: byte-addressed bus memory, per-port
// expected-response queues and randomized traffic in disjoint address regions.
module tb_mem_bus_arbiter;
   import mem_bus_pkg::*;

   localparam int MEM_LAT = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         p0_req, p0_we, p1_req, p1_we;
   logic [31:0]  p0_addr, p1_addr;
   logic [127:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata;
   logic         p0_ack, p1_ack;
   logic [31:0]  mem_addr_sel;
   logic [127:0] mem_dat_o, mem_dat_i;
   logic         mem_dat_oe, mem_en, mem_we, mem_re;

   int checks = 0;
   int passes = 0;
   int cyc = 0;

   logic [127:0] exp_q0[$];
   logic [127:0] exp_q1[$];
   int           ack_log[$];
   int           ack_cyc[$];
   logic [7:0]   bus_mem[logic [31:0]];
   logic [7:0]   ref_mem[logic [31:0]];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   mem_bus_arbiter #(.ADDR_W(32), .DATA_W(128), .MEM_LAT(MEM_LAT), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_ack(p0_ack), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_ack(p1_ack), .p1_rdata(p1_rdata),
      .mem_addr_sel(mem_addr_sel), .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i),
      .mem_dat_oe(mem_dat_oe), .mem_en(mem_en), .mem_we(mem_we), .mem_re(mem_re)
   );

   function automatic logic [7:0] dflt(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction

   function automatic logic [127:0] rd_ref(input logic [31:0] a);
      logic [127:0] r;
      for (int i = 0; i < 16; i++)
         r[8*i +: 8] = ref_mem.exists(a + 32'(i)) ? ref_mem[a + 32'(i)] : dflt(a + 32'(i));
      return r;
   endfunction

   function automatic logic [127:0] rd_bus(input logic [31:0] a);
      logic [127:0] r;
      for (int i = 0; i < 16; i++)
         r[8*i +: 8] = bus_mem.exists(a + 32'(i)) ? bus_mem[a + 32'(i)] : dflt(a + 32'(i));
      return r;
   endfunction

   // Memory acts on the falling edge; junk on mem_dat_i when not reading.
   always @(negedge clk) begin
      if (mem_en && mem_we)
         for (int i = 0; i < 16; i++) bus_mem[mem_addr_sel + 32'(i)] = mem_dat_o[8*i +: 8];
      if (mem_en && mem_re) mem_dat_i = rd_bus(mem_addr_sel);
      else mem_dat_i = {$urandom, $urandom, $urandom, $urandom};
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (p0_ack && p1_ack) begin
            checks++;
            $display("FAIL both_ack: got p0_ack=1 p1_ack=1 expected at most one");
         end
         if (p0_ack) begin
            ack_log.push_back(0);
            ack_cyc.push_back(cyc);
            if (exp_q0.size() == 0) begin
               checks++;
               $display("FAIL p0_unexpected_ack: got ack=1 expected ack=0");
            end else chk("p0_rdata", p0_rdata, exp_q0.pop_front());
         end
         if (p1_ack) begin
            ack_log.push_back(1);
            ack_cyc.push_back(cyc);
            if (exp_q1.size() == 0) begin
               checks++;
               $display("FAIL p1_unexpected_ack: got ack=1 expected ack=0");
            end else chk("p1_rdata", p1_rdata, exp_q1.pop_front());
         end
      end
   end

   task automatic drive(input int port, input bit req, input bit we,
                        input logic [31:0] addr, input logic [127:0] wd);
      if (port == 0) begin
         p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wd;
      end else begin
         p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wd;
      end
   endtask

   // Issues one transaction, pushes its expected rdata, waits (bounded) for the ack.
   // lat counts falling edges from issue to ack; the issue cycle is cycle 1 of the latency.
   task automatic txn(input int port, input bit we, input logic [31:0] addr,
                      input logic [127:0] wd, input bit hold, input bit mutate,
                      output int lat, output int en_cnt, output int bus_bad, output int other_acks);
      logic [127:0] e;
      bit           done;
      done = 1'b0;
      e = we ? 128'h0 : rd_ref(addr);
      if (we) for (int i = 0; i < 16; i++) ref_mem[addr + 32'(i)] = wd[8*i +: 8];
      if (port == 0) exp_q0.push_back(e);
      else exp_q1.push_back(e);
      drive(port, 1'b1, we, addr, wd);
      lat = 0; en_cnt = 0; bus_bad = 0; other_acks = 0;
      while (!done && lat < 64) begin
         @(negedge clk);
         lat++;
         if (mem_en) begin
            en_cnt++;
            if (mem_addr_sel !== addr || mem_we !== we || mem_re !== !we ||
                mem_dat_oe !== we || mem_dat_o !== (we ? wd : 128'h0))
               bus_bad++;
         end
         if ((port == 0) ? p0_ack : p1_ack) done = 1'b1;
         else if ((port == 0) ? p1_ack : p0_ack) other_acks++;
         if (mutate && lat == 1) drive(port, 1'b1, !we, 32'h80, ~wd);
      end
      if (!done) begin
         checks++;
         $display("FAIL txn_timeout port%0d: got no ack after %0d cycles expected ack", port, lat);
      end
      if (!hold) drive(port, 1'b0, 1'b0, 32'h0, 128'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive(0, 0, 0, 32'h0, 128'h0);
      drive(1, 0, 0, 32'h0, 128'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic chain(input int port, input logic [31:0] base);
      int lat, en, bad, oth;
      for (int k = 0; k < 2; k++)
         txn(port, 1'b0, base + 32'(k * 16), 128'h0, (k == 0), 1'b0, lat, en, bad, oth);
   endtask

   task automatic rand_port(input int port, input logic [31:0] base, input int n);
      int lat, en, bad, oth;
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         txn(port, 1'($urandom_range(0, 1)), base + 32'($urandom_range(0, 255)),
             {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, lat, en, bad, oth);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation time limit expected completion");
      $fatal(1);
   end

   initial begin
      int lat, en, bad, oth, n_ack;
      logic [127:0] line;
      int exp_order[4];

      rst = 1'b1;
      drive(0, 0, 0, 32'h0, 128'h0);
      drive(1, 0, 0, 32'h0, 128'h0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_ctrl", {p0_ack, p1_ack, mem_en, mem_we, mem_re, mem_dat_oe}, 0);
      chk("reset_addr", mem_addr_sel, 0);
      chk("reset_dat_o", mem_dat_o, 0);
      chk("reset_rdata", p0_rdata, 0);

      // p0 read of a known line
      line = 128'h0123456789ABCDEF0123456789ABCDEF;
      for (int i = 0; i < 16; i++) begin
         ref_mem[32'h40 + 32'(i)] = line[8*i +: 8];
         bus_mem[32'h40 + 32'(i)] = line[8*i +: 8];
      end
      @(negedge clk);
      txn(0, 1'b0, 32'h40, 128'h0, 1'b0, 1'b0, lat, en, bad, oth);
      chk("rd_latency", lat, MEM_LAT + 1);
      chk("rd_en_cycles", en, MEM_LAT);
      chk("rd_bus_fields", bad, 0);
      chk("rd_other_ack", oth, 0);

      // p1 unaligned write
      repeat (2) @(negedge clk);
      txn(1, 1'b1, 32'h000100FF, {16{8'hA5}}, 1'b0, 1'b0, lat, en, bad, oth);
      chk("wr_latency", lat, MEM_LAT + 1);
      chk("wr_en_cycles", en, MEM_LAT);
      chk("wr_bus_fields", bad, 0);
      chk("wr_other_ack", oth, 0);
      for (int i = 0; i < 16; i++)
         chk("wr_mem_byte", bus_mem.exists(32'h100FF + 32'(i)) ? bus_mem[32'h100FF + 32'(i)] : 8'h00, 8'hA5);

      // contention: both ports hold requests for two transactions each
      do_reset();
      ack_log.delete();
      ack_cyc.delete();
      fork
         chain(0, 32'h3000);
         chain(1, 32'h9000);
      join
      @(negedge clk);
`ifdef MEM_BUS_ARB_RR_EN
      exp_order = '{0, 1, 0, 1};
`else
      exp_order = '{1, 1, 0, 0};
`endif
      chk("contend_acks", ack_log.size(), 4);
      for (int i = 0; i < 4 && i < ack_log.size(); i++) chk("contend_order", ack_log[i], exp_order[i]);
      for (int i = 1; i < 4 && i < ack_cyc.size(); i++) chk("contend_gap", ack_cyc[i] - ack_cyc[i-1], MEM_LAT + 2);

      // command fields change one cycle after the grant
      repeat (2) @(negedge clk);
      txn(0, 1'b0, 32'h40, 128'h0, 1'b0, 1'b1, lat, en, bad, oth);
      chk("latch_bus_fields", bad, 0);
      chk("latch_en_cycles", en, MEM_LAT);

      // reset in the first ACCESS cycle aborts without ack
      repeat (2) @(negedge clk);
      drive(0, 1'b1, 1'b0, 32'h200, 128'h0);
      @(negedge clk);
      chk("abort_en_before", mem_en, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_bus_off", {mem_en, mem_we, mem_re, mem_dat_oe}, 0);
      rst = 1'b0;
      drive(0, 1'b0, 1'b0, 32'h0, 128'h0);
      n_ack = 0;
      repeat (6) begin
         @(negedge clk);
         if (p0_ack || p1_ack) n_ack++;
      end
      chk("abort_no_ack", n_ack, 0);
      txn(0, 1'b0, 32'h200, 128'h0, 1'b0, 1'b0, lat, en, bad, oth);
      chk("after_reset_latency", lat, MEM_LAT + 1);

      // randomized concurrent traffic, each port in its own region
      repeat (2) @(negedge clk);
      fork
         rand_port(0, 32'h1000, 40);
         rand_port(1, 32'h8000, 40);
      join
      repeat (4) @(negedge clk);
      chk("q0_drained", exp_q0.size(), 0);
      chk("q1_drained", exp_q1.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-port arbiter/sequencer for the single shared 128-bit SoC memory bus (addr/data/en/we/re).
- Port 0 is instruction-side (icache line fill); port 1 is data-side (dcache fill/writeback, LSU).
- Grants one requester at a time, latches its command, and drives the bus for a fixed access time.
- Returns read data and a one-cycle ack to the granted port; sits between the cache subsystem and the memory pins at the soc boundary.

Parameters:
- ADDR_W, 32, memory address width.
- DATA_W, 128, bus/line width in bits.
- MEM_LAT, 2, cycles the bus command is held before read data is sampled (>=1).
- CNT_W, 4, width of the access counter (must hold MEM_LAT).

Ports:
- clk  in  1  core/bus clock; memory samples on its falling edge.
- rst  in  1  synchronous, active-high reset.
- p0_req  in  1  port 0 request; held until p0_ack.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_addr  in  ADDR_W  port 0 byte address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_ack  out  1  one-cycle completion pulse.
- p0_rdata  out  DATA_W  read data, valid while p0_ack=1.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata  (as port 0, for port 1).
- mem_addr_sel  out  ADDR_W  bus address.
- mem_dat_o  out  DATA_W  bus write data.
- mem_dat_i  in  DATA_W  bus read data.
- mem_dat_oe  out  1  write-data drive enable; the top level builds the tristate from this.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_re  out  1  memory read enable.

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values: all outputs 0, state IDLE, counter 0, last-grant = port 1.
- IDLE:
  - Any req=1 selects a winner and latches its we/addr/wdata plus the winner id.
  - Next state is ACCESS and the counter loads MEM_LAT-1.
  - With no request, stay in IDLE.
- ACCESS:
  - mem_en=1; mem_addr_sel holds the latched address.
  - Read: mem_re=1, mem_we=0, mem_dat_oe=0.
  - Write: mem_we=1, mem_re=0, mem_dat_oe=1, mem_dat_o = latched wdata.
  - The counter decrements each cycle. In the cycle the counter reaches 0, read data is captured from mem_dat_i into the rdata register, and the next state is RESP.
- RESP:
  - All mem_* outputs are 0.
  - The winner's ack=1 for exactly one cycle with rdata. Rdata is 0 for writes and holds its value after ack.
  - Next state is IDLE.
- Latency: request to ack is MEM_LAT+2 cycles. Back-to-back transactions are separated by one IDLE cycle, giving a throughput of one per MEM_LAT+2 cycles.
- Fixed priority (default): on simultaneous requests, port 1 (data) wins.
- Bus outputs are registered; no combinational path from p*_req to mem_*.
- Command latching: changes to addr/we/wdata after the grant are ignored.
- A request dropped before its grant is withdrawn silently.
- A request dropped after its grant still completes, and its ack still pulses.
- Non-granted ports see ack=0. The loser is served on the next IDLE if it is still requesting.
- Address is passed through unmodified; alignment is the requester's responsibility.
- Reset in any state forces IDLE at the next edge and drops mem_en/we/re/oe. No ack is issued for the aborted transaction.
- If a requester holds req after its ack, a new transaction is started.

Optional Feature:
- MEM_BUS_ARB_RR_EN defined: round-robin arbitration. On simultaneous requests, the port not granted last wins. Last-grant updates on every grant.
- Undefined: fixed priority, port 1 over port 0; the last-grant register is not implemented.

Decomposition:
- Shared package mem_bus_pkg:
  - arb_state_t enum {IDLE, ACCESS, RESP};
  - mem_cmd_t struct {we, addr[ADDR_W], wdata[DATA_W]};
  - port id constants PORT_I=0, PORT_D=1.
- One natural sub-module, mem_arb_pick: a combinational two-way picker with inputs req[1:0] and last_grant, outputs grant_valid and grant_id. It contains the MEM_BUS_ARB_RR_EN switch.
- The FSM, counter and datapath registers stay in mem_bus_arbiter.

Test Plan:
- Read, MEM_LAT=2: p0 read at addr 0x40, memory returns 0x0123..CDEF.
  - mem_en=mem_re=1 for 2 cycles with mem_addr_sel=0x40.
  - p0_ack at cycle 4 with p0_rdata=0x0123..CDEF; p1_ack stays 0.
- Write: p1 write to 0x000100FF, wdata 0xA5 repeated.
  - mem_we=mem_dat_oe=1 for 2 cycles.
  - Memory bytes 0x100FF..0x1010E equal 0xA5; p1_ack pulses at cycle 4 with p1_rdata=0.
- Contention, fixed priority: p0 and p1 requesting together in the same cycle.
  - p1 is served first; p0 is acked MEM_LAT+2 cycles after p1's ack.
- Contention with MEM_BUS_ARB_RR_EN: both ports requesting continuously for 4 transactions.
  - Grant sequence p0, p1, p0, p1 (last-grant resets to port 1, so p0 wins first).
- Command latching: change p0_addr 0x40 to 0x80 one cycle after the grant.
  - Bus still shows 0x40.
- Reset mid-ACCESS: assert rst for 1 cycle during the first ACCESS cycle.
  - mem_en=0 on the next edge; no ack.
  - A request after reset completes normally in MEM_LAT+2 cycles.
